rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive CPU grants while the coprocessor waits.
REQ-002 MCLK  in  1  system clock; all logic rising-edge.
REQ-003 RESET  in  1  reset, synchronous, active-high.
REQ-004 ROM_MASK  in  24  address mask applied to every granted address.
REQ-005 REFRESH  in  1  when high, no new grant is issued.
REQ-006 CPU_REQ / CPU_ADDR / CPU_WORD  in  1/24/1  CPU-bus ROM read request, address, 16-bit flag.
REQ-007 CPU_ACK / CPU_Q  out  1/16  one-cycle completion pulse and read data.
REQ-008 COP_REQ / COP_ADDR / COP_WORD  in  1/24/1  coprocessor ROM read request, address, 16-bit flag.
REQ-009 COP_ACK / COP_Q  out  1/16  one-cycle completion pulse and read data.
REQ-010 ROM_ADDR / ROM_WORD / ROM_CE_N / ROM_OE_N  out  24/1/1/1  shared ROM port.
REQ-011 ROM_RDY / ROM_Q  in  1/16  memory completion strobe and data.
REQ-012 BUSY  out  1  high while any access is outstanding.

Function
REQ-013 States: IDLE, GRANT_CPU, GRANT_COP; exactly one access is outstanding at a time.
REQ-014 IDLE -> GRANT_CPU when CPU_REQ=1, REFRESH=0, and the starvation count is below STARVE_MAX or COP_REQ=0.
REQ-015 IDLE -> GRANT_COP when COP_REQ=1, REFRESH=0, and either CPU_REQ=0 or the starvation count equals STARVE_MAX.
REQ-016 On a grant, ROM_ADDR SHALL be the requester address AND ROM_MASK, and ROM_WORD the requester flag, registered on the transition edge and held constant until completion.
REQ-017 ROM_CE_N=0 and ROM_OE_N=0 in GRANT_*; both are 1 in IDLE.
REQ-018 On ROM_RDY=1 in GRANT_x: ROM_Q is registered to x_Q, x_ACK pulses for exactly one cycle (the next cycle), and the state returns to IDLE.
REQ-019 Minimum grant-to-grant spacing is 2 cycles (completion cycle, then IDLE).
REQ-020 x_Q holds its last value until the next ACK to that requester.
REQ-021 Requesters hold REQ and ADDR until ACK; a REQ deasserted mid-grant does not abort the access, and the ACK is still issued.
REQ-022 Starvation counter, width clog2(STARVE_MAX+1): +1 on each CPU grant while COP_REQ=1; cleared on a COP grant or when COP_REQ=0; saturates at STARVE_MAX.
REQ-023 REFRESH rising during GRANT_* does not affect the outstanding access; it only blocks grants from IDLE.
REQ-024 ROM_RDY in IDLE is ignored: no ACK, no state change.
REQ-025 BUSY = (state != IDLE).

Reset
REQ-026 While RESET=1 at a clock edge: state=IDLE, ROM_CE_N=ROM_OE_N=1, ROM_ADDR=0, ROM_WORD=0, CPU_ACK=COP_ACK=0, CPU_Q=COP_Q=0, starvation counter=0.
REQ-027 Reset asserted mid-access drops the access without ACK; a ROM_RDY arriving after reset is ignored.
REQ-028 The first grant occurs no earlier than the first edge after RESET deasserts.

Structure
REQ-029 The state encoding and STARVE_MAX default SHALL live in the shared SNES mapper package.
REQ-030 The block is a single module with no sub-modules; the starvation logic is inline.

Verification
REQ-031 Single request: CPU_REQ, CPU_ADDR=0x123456, ROM_MASK=0x0FFFFF -> ROM_ADDR=0x023456 with CE/OE low; ROM_RDY with Q=0xBEEF -> CPU_ACK one cycle later, CPU_Q=0xBEEF.
REQ-032 Simultaneous CPU_REQ and COP_REQ held continuously -> grant order CPU, CPU, CPU, CPU, COP, repeating.
REQ-033 REFRESH=1 with both requests pending for 10 cycles -> no grant and CE_N=1 throughout; the CPU is granted the cycle after REFRESH falls.
REQ-034 RESET pulsed during GRANT_COP with ROM_RDY one cycle later -> no COP_ACK, state IDLE, all outputs at reset values.
REQ-035 ROM_RDY pulsed in IDLE -> no ACK, BUSY stays 0; COP_REQ dropped mid-grant -> COP_ACK still issued.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared definitions for the SNES mapper ROM arbiter.
//   arb_state_t        - arbiter FSM encoding (IDLE, GRANT_CPU, GRANT_COP)
//   STARVE_MAX_DEFAULT - default cap on consecutive CPU grants while the
//                        coprocessor is waiting
//   ADDR_W / DATA_W    - ROM address and data widths
package rom_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_CPU = 2'd1,
        ST_GRANT_COP = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int ADDR_W             = 24;
    localparam int DATA_W             = 16;

endpackage

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester (CPU, coprocessor) arbiter for a single shared ROM
// port. One access is outstanding at a time. The CPU has priority, but after
// STARVE_MAX consecutive CPU grants with the coprocessor waiting, the
// coprocessor gets the next grant.
//
// Ports
//   MCLK, RESET                  clock, synchronous active-high reset
//   ROM_MASK                     address mask applied to every granted address
//   REFRESH                      blocks new grants while high
//   CPU_REQ/ADDR/WORD            CPU read request, address, 16-bit flag
//   CPU_ACK/CPU_Q                CPU one-cycle completion pulse, read data
//   COP_REQ/ADDR/WORD            coprocessor read request, address, flag
//   COP_ACK/COP_Q                coprocessor completion pulse, read data
//   ROM_ADDR/WORD/CE_N/OE_N      shared ROM port (address/flag held per grant)
//   ROM_RDY/ROM_Q                ROM completion strobe and data
//   BUSY                         high while an access is outstanding
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ROM_MASK,
    input  logic              REFRESH,
    input  logic              CPU_REQ,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic              CPU_WORD,
    output logic              CPU_ACK,
    output logic [DATA_W-1:0] CPU_Q,
    input  logic              COP_REQ,
    input  logic [ADDR_W-1:0] COP_ADDR,
    input  logic              COP_WORD,
    output logic              COP_ACK,
    output logic [DATA_W-1:0] COP_Q,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_WORD,
    output logic              ROM_CE_N,
    output logic              ROM_OE_N,
    input  logic              ROM_RDY,
    input  logic [DATA_W-1:0] ROM_Q,
    output logic              BUSY
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_cpu, grant_cop;

    // Grant decisions are only meaningful from IDLE. The counter saturates at
    // STARVE_LIM, so the two conditions are mutually exclusive.
    always_comb begin
        grant_cpu = 1'b0;
        grant_cop = 1'b0;
        if (state == ST_IDLE && !REFRESH) begin
            grant_cpu = CPU_REQ && (starve_cnt < STARVE_LIM || !COP_REQ);
            grant_cop = COP_REQ && (!CPU_REQ || starve_cnt == STARVE_LIM);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_cpu)      state_nxt = ST_GRANT_CPU;
                else if (grant_cop) state_nxt = ST_GRANT_COP;
            end
            ST_GRANT_CPU,
            ST_GRANT_COP: begin
                if (ROM_RDY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ROM address/flag captured on the grant edge and held for the access.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            ROM_ADDR <= '0;
            ROM_WORD <= 1'b0;
        end else if (grant_cpu) begin
            ROM_ADDR <= CPU_ADDR & ROM_MASK;
            ROM_WORD <= CPU_WORD;
        end else if (grant_cop) begin
            ROM_ADDR <= COP_ADDR & ROM_MASK;
            ROM_WORD <= COP_WORD;
        end
    end

    // Completion: data captured and ACK pulsed the cycle after ROM_RDY.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            CPU_ACK <= 1'b0;
            COP_ACK <= 1'b0;
            CPU_Q   <= '0;
            COP_Q   <= '0;
        end else begin
            CPU_ACK <= 1'b0;
            COP_ACK <= 1'b0;
            if (ROM_RDY && state == ST_GRANT_CPU) begin
                CPU_ACK <= 1'b1;
                CPU_Q   <= ROM_Q;
            end
            if (ROM_RDY && state == ST_GRANT_COP) begin
                COP_ACK <= 1'b1;
                COP_Q   <= ROM_Q;
            end
        end
    end

    // Counts CPU grants issued while the coprocessor is waiting.
    always_ff @(posedge MCLK) begin
        if (RESET)
            starve_cnt <= '0;
        else if (!COP_REQ || grant_cop)
            starve_cnt <= '0;
        else if (grant_cpu && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    assign BUSY     = (state != ST_IDLE);
    assign ROM_CE_N = (state == ST_IDLE);
    assign ROM_OE_N = (state == ST_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench for rom_arbiter (STARVE_MAX = 4).
module tb_rom_arbiter;

    logic        MCLK = 1'b0;
    logic        RESET, REFRESH, ROM_RDY;
    logic [23:0] ROM_MASK, CPU_ADDR, COP_ADDR, ROM_ADDR;
    logic        CPU_REQ, CPU_WORD, COP_REQ, COP_WORD;
    logic        CPU_ACK, COP_ACK, ROM_WORD, ROM_CE_N, ROM_OE_N, BUSY;
    logic [15:0] CPU_Q, COP_Q, ROM_Q;

    int n_chk = 0;
    int n_fail = 0;

    always #5 MCLK = ~MCLK;

    rom_arbiter #(.STARVE_MAX(4)) dut (
        .MCLK(MCLK), .RESET(RESET), .ROM_MASK(ROM_MASK), .REFRESH(REFRESH),
        .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_WORD(CPU_WORD),
        .CPU_ACK(CPU_ACK), .CPU_Q(CPU_Q),
        .COP_REQ(COP_REQ), .COP_ADDR(COP_ADDR), .COP_WORD(COP_WORD),
        .COP_ACK(COP_ACK), .COP_Q(COP_Q),
        .ROM_ADDR(ROM_ADDR), .ROM_WORD(ROM_WORD), .ROM_CE_N(ROM_CE_N),
        .ROM_OE_N(ROM_OE_N), .ROM_RDY(ROM_RDY), .ROM_Q(ROM_Q), .BUSY(BUSY)
    );

    typedef struct {
        logic        rst, refresh, cpu_req, cpu_word, cop_req, cop_word, rdy;
        logic [23:0] cpu_addr, cop_addr, mask;
        logic [15:0] q;
        logic        busy, rom_word, cpu_ack, cop_ack;
        logic [23:0] rom_addr;
        logic [15:0] cpu_q, cop_q;
    } vec_t;

    function automatic vec_t mk(
        logic rst, logic refresh,
        logic cpu_req, logic [23:0] cpu_addr, logic cpu_word,
        logic cop_req, logic [23:0] cop_addr, logic cop_word,
        logic [23:0] mask, logic rdy, logic [15:0] q,
        logic busy, logic [23:0] rom_addr, logic rom_word,
        logic cpu_ack, logic [15:0] cpu_q, logic cop_ack, logic [15:0] cop_q);
        vec_t v;
        v.rst = rst; v.refresh = refresh;
        v.cpu_req = cpu_req; v.cpu_addr = cpu_addr; v.cpu_word = cpu_word;
        v.cop_req = cop_req; v.cop_addr = cop_addr; v.cop_word = cop_word;
        v.mask = mask; v.rdy = rdy; v.q = q;
        v.busy = busy; v.rom_addr = rom_addr; v.rom_word = rom_word;
        v.cpu_ack = cpu_ack; v.cpu_q = cpu_q; v.cop_ack = cop_ack; v.cop_q = cop_q;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic idle_inputs();
        RESET = 1'b0; REFRESH = 1'b0; ROM_RDY = 1'b0; ROM_Q = '0;
        CPU_REQ = 1'b0; CPU_WORD = 1'b0; COP_REQ = 1'b0; COP_WORD = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        int cyc;
        logic exp_cop;
        idle_inputs();
        ROM_MASK = 24'h0FFFFF; CPU_ADDR = '0; COP_ADDR = '0;

        // ---------------- table-driven vectors ----------------
        //          rst ref cpu addr        w  cop addr        w  mask         rdy q         busy addr       w  cak cq        oak oq
        tbl[0] = mk(1, 0,  0, 24'h000000, 0, 0, 24'h000000, 0, 24'h0FFFFF, 0, 16'h0000, 0, 24'h000000, 0, 0, 16'h0000, 0, 16'h0000);
        tbl[1] = mk(0, 0,  1, 24'h123456, 1, 0, 24'h000000, 0, 24'h0FFFFF, 0, 16'h0000, 1, 24'h023456, 1, 0, 16'h0000, 0, 16'h0000);
        tbl[2] = mk(0, 0,  0, 24'h123456, 1, 0, 24'h000000, 0, 24'h0FFFFF, 0, 16'h0000, 1, 24'h023456, 1, 0, 16'h0000, 0, 16'h0000);
        tbl[3] = mk(0, 0,  0, 24'h123456, 1, 0, 24'h000000, 0, 24'h0FFFFF, 1, 16'hBEEF, 0, 24'h023456, 1, 1, 16'hBEEF, 0, 16'h0000);
        tbl[4] = mk(0, 0,  0, 24'h123456, 1, 0, 24'h000000, 0, 24'h0FFFFF, 0, 16'h0000, 0, 24'h023456, 1, 0, 16'hBEEF, 0, 16'h0000);
        tbl[5] = mk(0, 0,  0, 24'h123456, 1, 0, 24'h000000, 0, 24'h0FFFFF, 1, 16'h1111, 0, 24'h023456, 1, 0, 16'hBEEF, 0, 16'h0000);
        tbl[6] = mk(0, 0,  0, 24'h123456, 1, 1, 24'hABCDEF, 0, 24'hFFFFFF, 0, 16'h0000, 1, 24'hABCDEF, 0, 0, 16'hBEEF, 0, 16'h0000);
        tbl[7] = mk(0, 0,  0, 24'h123456, 1, 0, 24'hABCDEF, 0, 24'hFFFFFF, 0, 16'h0000, 1, 24'hABCDEF, 0, 0, 16'hBEEF, 0, 16'h0000);
        tbl[8] = mk(0, 0,  0, 24'h123456, 1, 0, 24'hABCDEF, 0, 24'hFFFFFF, 1, 16'hCAFE, 0, 24'hABCDEF, 0, 0, 16'hBEEF, 1, 16'hCAFE);
        tbl[9] = mk(0, 0,  0, 24'h123456, 1, 0, 24'hABCDEF, 0, 24'hFFFFFF, 0, 16'h0000, 0, 24'hABCDEF, 0, 0, 16'hBEEF, 0, 16'hCAFE);

        for (int i = 0; i < 10; i++) begin
            RESET = tbl[i].rst; REFRESH = tbl[i].refresh;
            CPU_REQ = tbl[i].cpu_req; CPU_ADDR = tbl[i].cpu_addr; CPU_WORD = tbl[i].cpu_word;
            COP_REQ = tbl[i].cop_req; COP_ADDR = tbl[i].cop_addr; COP_WORD = tbl[i].cop_word;
            ROM_MASK = tbl[i].mask; ROM_RDY = tbl[i].rdy; ROM_Q = tbl[i].q;
            tick();
            chk($sformatf("v%0d.busy", i), 32'(BUSY), 32'(tbl[i].busy));
            chk($sformatf("v%0d.ce_n", i), 32'(ROM_CE_N), 32'(!tbl[i].busy));
            chk($sformatf("v%0d.oe_n", i), 32'(ROM_OE_N), 32'(!tbl[i].busy));
            chk($sformatf("v%0d.rom_addr", i), 32'(ROM_ADDR), 32'(tbl[i].rom_addr));
            chk($sformatf("v%0d.rom_word", i), 32'(ROM_WORD), 32'(tbl[i].rom_word));
            chk($sformatf("v%0d.cpu_ack", i), 32'(CPU_ACK), 32'(tbl[i].cpu_ack));
            chk($sformatf("v%0d.cpu_q", i), 32'(CPU_Q), 32'(tbl[i].cpu_q));
            chk($sformatf("v%0d.cop_ack", i), 32'(COP_ACK), 32'(tbl[i].cop_ack));
            chk($sformatf("v%0d.cop_q", i), 32'(COP_Q), 32'(tbl[i].cop_q));
        end
        idle_inputs();

        // ---------------- reset mid-access (COP grant) ----------------
        COP_REQ = 1'b1; COP_ADDR = 24'h654321; COP_WORD = 1'b1; ROM_MASK = 24'hFFFFFF;
        tick();
        chk("rst_mid.grant_busy", 32'(BUSY), 32'd1);
        chk("rst_mid.grant_addr", 32'(ROM_ADDR), 32'h654321);
        RESET = 1'b1; COP_REQ = 1'b0;
        tick();
        chk("rst_mid.busy", 32'(BUSY), 32'd0);
        chk("rst_mid.ce_n", 32'(ROM_CE_N), 32'd1);
        chk("rst_mid.oe_n", 32'(ROM_OE_N), 32'd1);
        chk("rst_mid.rom_addr", 32'(ROM_ADDR), 32'd0);
        chk("rst_mid.rom_word", 32'(ROM_WORD), 32'd0);
        chk("rst_mid.cpu_q", 32'(CPU_Q), 32'd0);
        chk("rst_mid.cop_q", 32'(COP_Q), 32'd0);
        chk("rst_mid.acks", 32'({CPU_ACK, COP_ACK}), 32'd0);
        RESET = 1'b0; ROM_RDY = 1'b1; ROM_Q = 16'h9999;
        tick();
        ROM_RDY = 1'b0;
        chk("rst_late_rdy.cop_ack", 32'(COP_ACK), 32'd0);
        chk("rst_late_rdy.busy", 32'(BUSY), 32'd0);
        chk("rst_late_rdy.cop_q", 32'(COP_Q), 32'd0);
        tick();
        chk("rst_late_rdy.cop_ack2", 32'(COP_ACK), 32'd0);

        // ---------------- starvation: CPU x4 then COP ----------------
        RESET = 1'b1; tick(); RESET = 1'b0;
        ROM_MASK = 24'hFFFFFF; CPU_ADDR = 24'h000100; COP_ADDR = 24'h000200;
        CPU_REQ = 1'b1; COP_REQ = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_cop = (g % 5 == 4);
            cyc = 0;
            while (!BUSY && cyc < 8) begin
                tick();
                cyc++;
            end
            chk($sformatf("starve.g%0d.spacing", g), 32'(cyc), 32'd1);
            chk($sformatf("starve.g%0d.who", g), 32'(ROM_ADDR),
                exp_cop ? 32'h000200 : 32'h000100);
            ROM_RDY = 1'b1; ROM_Q = 16'(16'hA000 + g);
            tick();
            ROM_RDY = 1'b0;
            if (g == 9) begin
                CPU_REQ = 1'b0; COP_REQ = 1'b0;
            end
            chk($sformatf("starve.g%0d.acks", g), 32'({CPU_ACK, COP_ACK}),
                exp_cop ? 32'd1 : 32'd2);
            chk($sformatf("starve.g%0d.q", g), 32'(exp_cop ? COP_Q : CPU_Q),
                32'(16'hA000 + g));
        end
        tick();
        chk("starve.end_idle", 32'(BUSY), 32'd0);

        // ---------------- REFRESH blocking ----------------
        RESET = 1'b1; tick(); RESET = 1'b0;
        REFRESH = 1'b1; CPU_REQ = 1'b1; COP_REQ = 1'b1;
        CPU_ADDR = 24'h000111; COP_ADDR = 24'h000222;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("refresh.c%0d.busy_ce", c), 32'({BUSY, ROM_CE_N}), 32'd1);
        end
        REFRESH = 1'b0;
        tick();
        chk("refresh.after.busy", 32'(BUSY), 32'd1);
        chk("refresh.after.addr", 32'(ROM_ADDR), 32'h000111);
        // REFRESH rising mid-grant must not disturb the access
        REFRESH = 1'b1; CPU_REQ = 1'b0; COP_REQ = 1'b0;
        tick();
        chk("refresh.mid.busy", 32'(BUSY), 32'd1);
        ROM_RDY = 1'b1; ROM_Q = 16'h5A5A;
        tick();
        ROM_RDY = 1'b0; REFRESH = 1'b0;
        chk("refresh.mid.cpu_ack", 32'(CPU_ACK), 32'd1);
        chk("refresh.mid.cpu_q", 32'(CPU_Q), 32'h5A5A);
        tick();
        chk("refresh.mid.ack_pulse", 32'(CPU_ACK), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
